// File: rtl/gray_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_mem_arbiter_pkg
// Description : Shared constants for the two-port gray image memory arbiter:
//               address/data widths, burst limit default, FSM state encoding
//               and a small helper mapping a requester id to its OWN state.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_mem_arbiter_pkg;

    localparam int ADDR_W            = 14;   // {y[6:0], x[6:0]} of 128x128 image
    localparam int DATA_W            = 8;
    localparam int MAX_BURST_DEFAULT = 9;    // one 3x3 kernel
    localparam int CNT_W             = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    function automatic logic [1:0] own_state(input logic id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : gray_arb_pick
// Description : Two-way round-robin pick. The requester named by the pointer
//               wins if it is requesting, otherwise the other one.
// Ports       : i_req  - request pair {r1, r0}
//               i_ptr  - round-robin pointer (preferred id)
//               o_any  - at least one request is pending
//               o_pick - id of the winning requester
// Revision    : 1.0 - initial release
// ============================================================================
module gray_arb_pick (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_any,
    output logic       o_pick
);

    assign o_any  = |i_req;
    assign o_pick = i_req[i_ptr] ? i_ptr : ~i_ptr;

endmodule
`default_nettype wire

// File: rtl/gray_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gray_mem_arbiter
// Description : Arbitrates two read requesters onto one gray image memory.
//               Ownership-based: the owner streams up to MAX_BURST grants
//               while the other waits; read data returns two cycles after
//               each grant, in grant order, on a shared rdata bus.
// Ports       : clk, reset             - clock, synchronous active-high reset
//               rN_req/rN_addr/rN_gnt  - requester N address channel
//               rN_rvalid, rdata       - read return (rdata shared)
//               gray_ready/req/addr/data - image memory interface
// Revision    : 1.0 - initial release
// ============================================================================
module gray_mem_arbiter
    import gray_mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DATA_W-1:0] gray_data
);

    localparam logic [CNT_W-1:0] c_burst_last = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] c_burst_max  = CNT_W'(MAX_BURST);

    logic [1:0]        r_state;
    logic              r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_gray_req;
    logic [ADDR_W-1:0] r_gray_addr;
    logic              r_s1_id;      // owner of the read currently on gray_req
    logic [DATA_W-1:0] r_rdata;
    logic              r_rv_valid;
    logic              r_rv_id;

    logic [1:0]        w_req;
    logic              w_any;
    logic              w_pick;
    logic              w_owning;
    logic              w_own_id;
    logic              w_other_id;
    logic              w_other_req;
    logic              w_gnt;
    logic              w_burst_done;
    logic [1:0]        w_state_nxt;
    logic              w_ptr_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_req = {r1_req, r0_req};

    gray_arb_pick u_pick (
        .i_req  (w_req),
        .i_ptr  (r_ptr),
        .o_any  (w_any),
        .o_pick (w_pick)
    );

    assign w_owning     = (r_state == OWN0) || (r_state == OWN1);
    assign w_own_id     = (r_state == OWN1);
    assign w_other_id   = ~w_own_id;
    assign w_other_req  = w_req[w_other_id];
    // Gated by reset so no grant leaks out while the block is being cleared.
    assign w_gnt        = ~reset & w_owning & gray_ready & w_req[w_own_id];
    // >= rather than == covers the saturated case: after a long solo burst the
    // owner gets one final grant in the cycle the other requester shows up.
    assign w_burst_done = (r_cnt >= c_burst_last);

    assign r0_gnt = w_gnt & ~w_own_id;
    assign r1_gnt = w_gnt &  w_own_id;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (gray_ready && w_any) begin
                    w_state_nxt = own_state(w_pick);
                    w_cnt_nxt   = '0;
                end
            end
            OWN0, OWN1: begin
                // A stalled memory freezes ownership and the burst count.
                if (gray_ready) begin
                    if (w_gnt) begin
                        if (w_burst_done && w_other_req) begin
                            w_state_nxt = own_state(w_other_id);
                            w_ptr_nxt   = w_other_id;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt != c_burst_max) begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else begin
                        w_ptr_nxt = w_other_id;
                        if (w_other_req) begin
                            w_state_nxt = own_state(w_other_id);
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_cnt       <= '0;
            r_gray_req  <= 1'b0;
            r_gray_addr <= '0;
            r_s1_id     <= 1'b0;
            r_rdata     <= '0;
            r_rv_valid  <= 1'b0;
            r_rv_id     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gray_req <= w_gnt;
            if (w_gnt) begin
                r_gray_addr <= w_own_id ? r1_addr : r0_addr;
                r_s1_id     <= w_own_id;
            end
            if (r_gray_req) begin
                r_rdata <= gray_data;
            end
            // Second stage of the source-id pipeline: reads retire in order.
            r_rv_valid <= r_gray_req;
            r_rv_id    <= r_s1_id;
        end
    end

    assign gray_req  = r_gray_req;
    assign gray_addr = r_gray_addr;
    assign rdata     = r_rdata;
    assign r0_rvalid = r_rv_valid & ~r_rv_id;
    assign r1_rvalid = r_rv_valid &  r_rv_id;

endmodule
`default_nettype wire

// File: tb/tb_gray_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_mem_arbiter
// Description : Self-checking bench for gray_mem_arbiter. Directed scenarios
//               followed by a randomized run, all compared every cycle against
//               a reference model built from owner/burst/pending-read lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_mem_arbiter;

    localparam int MAXB = 9;

    logic        clk = 1'b0;
    logic        reset, r0_req, r1_req, gray_ready;
    logic [13:0] r0_addr, r1_addr, gray_addr;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, gray_req;
    logic [7:0]  rdata, gray_data;

    // Memory model: each pixel reads back as the low byte of its address.
    assign gray_data = gray_addr[7:0];

    always #5 clk = ~clk;

    gray_mem_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .reset      (reset),
        .r0_req     (r0_req),
        .r1_req     (r1_req),
        .r0_addr    (r0_addr),
        .r1_addr    (r1_addr),
        .r0_gnt     (r0_gnt),
        .r1_gnt     (r1_gnt),
        .r0_rvalid  (r0_rvalid),
        .r1_rvalid  (r1_rvalid),
        .rdata      (rdata),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: who owns the memory, grants given in this burst,
    // preferred requester, and the list of reads waiting to return.
    typedef struct {
        int id;
        int addr;
        int due;
    } rd_t;

    rd_t pend[$];
    int  m_owner   = -1;
    int  m_ptr     = 0;
    int  m_burst   = 0;
    int  m_greq_at = -10;
    int  m_gaddr   = 0;
    int  m_rdata   = 0;
    bit  g0, g1;          // model grants of the cycle just finished
    int  ng0, ng1;        // model grant counters (stimulus pacing)
    int  dg0, dg1;        // DUT grants observed
    int  drv0, drv1;      // DUT rvalids observed
    int  last_rd0;
    int  last_g0_cyc, first_g1_cyc;
    int  snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit rq(input int id, input bit a, input bit b);
        return (id == 1) ? b : a;
    endfunction

    task automatic clr_obs();
        ng0 = 0; ng1 = 0; dg0 = 0; dg1 = 0; drv0 = 0; drv1 = 0;
        last_rd0 = -1; last_g0_cyc = -100; first_g1_cyc = -1;
    endtask

    // One clock cycle: inputs are already driven (at negedge); check all
    // outputs against the model, advance the model, step to next negedge.
    task automatic cycle();
        bit  q0, q1, e0, e1, erv0, erv1;
        int  edata;
        rd_t r;
        q0 = r0_req;
        q1 = r1_req;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!reset && m_owner >= 0 && gray_ready && rq(m_owner, q0, q1)) begin
            if (m_owner == 0) e0 = 1'b1; else e1 = 1'b1;
        end
        erv0  = 1'b0;
        erv1  = 1'b0;
        edata = m_rdata;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].id == 0) erv0 = 1'b1; else erv1 = 1'b1;
            edata = pend[0].addr % 256;
        end
        chk("r0_gnt",    32'(r0_gnt),    32'(e0));
        chk("r1_gnt",    32'(r1_gnt),    32'(e1));
        chk("gray_req",  32'(gray_req),  32'(m_greq_at == cyc));
        chk("gray_addr", 32'(gray_addr), 32'(m_gaddr));
        chk("r0_rvalid", 32'(r0_rvalid), 32'(erv0));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(erv1));
        chk("rdata",     32'(rdata),     32'(edata));

        if (r0_gnt === 1'b1) begin dg0++; last_g0_cyc = cyc; end
        if (r1_gnt === 1'b1) begin dg1++; if (first_g1_cyc < 0) first_g1_cyc = cyc; end
        if (r0_rvalid === 1'b1) begin drv0++; last_rd0 = int'(rdata); end
        if (r1_rvalid === 1'b1) drv1++;

        g0 = e0;
        g1 = e1;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_burst = 0;
            pend.delete();
            m_greq_at = -10; m_gaddr = 0; m_rdata = 0;
        end else begin
            if (erv0 || erv1) begin
                m_rdata = edata;
                void'(pend.pop_front());
            end
            if (e0 || e1) begin
                r.id   = e1 ? 1 : 0;
                r.addr = e1 ? int'(r1_addr) : int'(r0_addr);
                r.due  = cyc + 2;
                pend.push_back(r);
                m_greq_at = cyc + 1;
                m_gaddr   = r.addr;
            end
            if (gray_ready) begin
                if (m_owner < 0) begin
                    if (q0 || q1) begin
                        m_owner = rq(m_ptr, q0, q1) ? m_ptr : 1 - m_ptr;
                        m_burst = 0;
                    end
                end else if (rq(m_owner, q0, q1)) begin
                    m_burst++;
                    if (m_burst >= MAXB && rq(1 - m_owner, q0, q1)) begin
                        m_owner = 1 - m_owner;
                        m_ptr   = m_owner;
                        m_burst = 0;
                    end
                end else begin
                    m_ptr   = 1 - m_owner;
                    m_owner = rq(1 - m_owner, q0, q1) ? 1 - m_owner : -1;
                    m_burst = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        // Requesters move to the next address once granted.
        if (g0) begin r0_addr = r0_addr + 14'd1; ng0++; end
        if (g1) begin r1_addr = r1_addr + 14'd1; ng1++; end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
        clr_obs();
    endtask

    initial begin
        reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
        r0_addr = '0; r1_addr = '0; gray_ready = 1'b1;
        clr_obs();
        @(negedge clk);
        do_reset(2);

        // Reset state: everything quiet after release.
        #1;
        chk("rst_gray_req",  32'(gray_req),  32'd0);
        chk("rst_gray_addr", 32'(gray_addr), 32'd0);
        chk("rst_rdata",     32'(rdata),     32'd0);
        chk("rst_rvalid",    32'({r1_rvalid, r0_rvalid}), 32'd0);
        @(negedge clk);
        cyc++;

        // r0 alone: 9 reads from 0x0081
        r0_addr = 14'h0081; r0_req = 1'b1;
        for (int i = 0; i < 40 && ng0 < 9; i++) cycle();
        r0_req = 1'b0;
        repeat (4) cycle();
        chk("solo_grants",     32'(dg0),      32'd9);
        chk("solo_rvalids",    32'(drv0),     32'd9);
        chk("solo_last_rdata", 32'(last_rd0), 32'h89);

        // Both from IDLE with ptr=0: r0 first, r1 follows with no bubble
        do_reset(1);
        r0_addr = 14'h0100; r1_addr = 14'h0200; r0_req = 1'b1; r1_req = 1'b1;
        for (int i = 0; i < 40 && ng1 < 1; i++) cycle();
        chk("both_r0_first_burst", 32'(dg0), 32'd9);
        chk("both_no_bubble",      32'(first_g1_cyc - last_g0_cyc), 32'd1);
        repeat (24) cycle();
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (4) cycle();

        // r0 drops after 3 grants while r1 waits
        do_reset(1);
        r0_addr = 14'h0010; r1_addr = 14'h0020; r0_req = 1'b1; r1_req = 1'b1;
        for (int i = 0; i < 20 && ng0 < 3; i++) cycle();
        r0_req = 1'b0;
        cycle();
        cycle();
        chk("drop_r1_gnt", 32'(dg1), 32'd1);
        repeat (4) cycle();
        r1_req = 1'b0;
        repeat (4) cycle();
        chk("drop_r0_rvalids", 32'(drv0), 32'd3);

        // Memory stall mid-burst: burst count must freeze
        do_reset(1);
        r0_addr = 14'h0300; r1_addr = 14'h0380; r0_req = 1'b1; r1_req = 1'b1;
        for (int i = 0; i < 20 && ng0 < 4; i++) cycle();
        gray_ready = 1'b0;
        snap = dg0;
        repeat (5) cycle();
        chk("stall_no_gnt", 32'(dg0 - snap), 32'd0);
        gray_ready = 1'b1;
        for (int i = 0; i < 30 && ng1 < 1; i++) cycle();
        chk("stall_burst_len", 32'(dg0), 32'd9);
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (4) cycle();

        // Reset with reads in flight
        do_reset(1);
        r0_addr = 14'h0400; r0_req = 1'b1;
        for (int i = 0; i < 20 && ng0 < 2; i++) cycle();
        r0_req = 1'b0;
        do_reset(1);
        #1;
        chk("midrst_gray_req",  32'(gray_req),  32'd0);
        chk("midrst_gray_addr", 32'(gray_addr), 32'd0);
        @(negedge clk);
        cyc++;
        repeat (4) cycle();
        chk("midrst_no_rvalid", 32'(drv0 + drv1), 32'd0);

        // r1 alone for 12 grants, then r0 arrives
        do_reset(1);
        r1_addr = 14'h0500; r1_req = 1'b1;
        for (int i = 0; i < 30 && ng1 < 12; i++) cycle();
        chk("long_r1_grants", 32'(dg1), 32'd12);
        r0_addr = 14'h0600; r0_req = 1'b1;
        snap = dg1;
        for (int i = 0; i < 10 && ng0 < 1; i++) cycle();
        chk("long_extra_r1_le1", 32'((dg1 - snap) <= 1), 32'd1);
        chk("long_r0_owns",      32'(dg0),               32'd1);
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (4) cycle();

        // Randomized traffic with stalls and occasional resets
        for (int i = 0; i < 600; i++) begin
            if (!r0_req || g0) begin
                r0_req  = ($urandom_range(0, 3) != 0);
                r0_addr = 14'($urandom);
            end
            if (!r1_req || g1) begin
                r1_req  = ($urandom_range(0, 3) != 0);
                r1_addr = 14'($urandom);
            end
            gray_ready = ($urandom_range(0, 4) != 0);
            reset      = ($urandom_range(0, 80) == 0);
            cycle();
        end
        reset = 1'b0; r0_req = 1'b0; r1_req = 1'b0; gray_ready = 1'b1;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_mem_arbiter.md
GRAY_MEM_ARBITER -- requirements
Module: gray_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 9: maximum consecutive grants to one requester while the other waits (one 3x3 kernel).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports r0_req, r1_req, input, 1 bit each: requester N has a read pending.
REQ-005 SHALL have ports r0_addr, r1_addr, input, 14 bits each: read address, as {y[6:0], x[6:0]} of the 128x128 gray image.
REQ-006 SHALL have ports r0_gnt, r1_gnt, output, 1 bit each: requester N's address is accepted this cycle.
REQ-007 SHALL have ports r0_rvalid, r1_rvalid, output, 1 bit each: rdata holds requester N's read result this cycle.
REQ-008 SHALL have port rdata, output, 8 bits: read data shared by both requesters, qualified by rN_rvalid.
REQ-009 SHALL have port gray_ready, input, 1 bit: the image memory is available.
REQ-010 SHALL have port gray_req, output, 1 bit: the memory read strobe.
REQ-011 SHALL have port gray_addr, output, 14 bits: the memory read address.
REQ-012 SHALL have port gray_data, input, 8 bits: memory data, valid in the same cycle as gray_addr/gray_req.

Function
REQ-013 SHALL implement FSM states IDLE, OWN0 and OWN1, plus a 1-bit round-robin pointer ptr.
REQ-014 In IDLE with gray_ready=1 and any rN_req=1, the FSM SHALL go to OWN[ptr] if r[ptr]_req=1, otherwise to OWN of the other requester; IDLE issues no grant, giving a 1-cycle arbitration bubble.
REQ-015 In OWNn, rn_gnt SHALL equal rn_req AND gray_ready (combinational), and the other requester's gnt SHALL be 0.
REQ-016 On each rn_gnt, the block SHALL register gray_req=1 and gray_addr=rn_addr for the next cycle; otherwise gray_req SHALL be 0 and gray_addr SHALL hold its value.
REQ-017 The block SHALL register gray_data into rdata in the cycle gray_req=1, and assert the owning rN_rvalid the following cycle; grant-to-rvalid latency SHALL be exactly 2 cycles.
REQ-018 Reads SHALL complete in grant order, tracked by a 2-stage source-id pipeline; at most one rvalid SHALL be high per cycle.
REQ-019 A 4-bit burst counter SHALL clear on entering OWNn and increment on each rn_gnt.
REQ-020 In OWNn with rn_gnt=1, counter==MAX_BURST-1 and other requester req=1, the FSM SHALL go to OWN(other) with no bubble; ptr SHALL become the other id.
REQ-021 If the counter reaches MAX_BURST while the other requester is idle, ownership SHALL be kept and the counter SHALL saturate; the switch SHALL happen on the first later cycle in which the other requester has req=1.
REQ-022 In OWNn with rn_req=0: next state SHALL be OWN(other) if the other requester has req=1 and gray_ready=1, otherwise IDLE; ptr SHALL point at the other id.
REQ-023 With gray_ready=0, no gnt SHALL assert and state and counter SHALL hold; reads already issued SHALL still complete on schedule.
REQ-024 Requesters SHALL hold rN_addr stable while rN_req=1 and rN_gnt=0; the arbiter SHALL sample rN_addr only on a grant.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL enter IDLE and set ptr=0, counter=0, gray_req=0, gray_addr=0, rdata=0, both rvalid=0, and clear the source-id pipeline.
REQ-026 Reset mid-operation SHALL discard in-flight reads: no rvalid in the cycle after reset is sampled; gnt outputs SHALL be 0 while reset=1.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, ADDR_W=14, DATA_W=8 and the MAX_BURST default.
REQ-028 A single sub-module, gray_arb_pick (2-way round-robin pick from req pair and ptr), SHALL be used; all other logic SHALL stay flat.

Verification
REQ-029 The bench SHALL cover: r0 alone, 9 reads from addr 0x0081 upward, memory returns addr[7:0] -> r0_rvalid 2 cycles after each gnt, rdata 0x81..0x89.
REQ-030 The bench SHALL cover: both req from IDLE, ptr=0 -> r0 owns first; after 9 grants r1 gets gnt on the next cycle with no bubble.
REQ-031 The bench SHALL cover: r0 drops req after 3 grants while r1 waits -> r1_gnt next cycle; r0's 3 rvalids still arrive in order, never overlapping r1's.
REQ-032 The bench SHALL cover: gray_ready low for 5 cycles mid-burst -> no gnt and no new gray_req, counter frozen; burst resumes with the correct address.
REQ-033 The bench SHALL cover: reset for 1 cycle with 2 reads in flight -> no rvalid afterwards; state IDLE, gray_req=0, gray_addr=0.
REQ-034 The bench SHALL cover: r1 alone for 12 grants -> no forced switch; r0 then raises req -> r1 keeps at most one more gnt, then r0 owns.
